// File: rtl/vec_memory_stage.sv
// Memory stage with a single-port data array, serialising vector accesses one lane per cycle.
// Optional per-lane write/read masking is enabled by defining VMEM_LANE_MASK_EN.
module vec_memory_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned REG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      validM,
    input  logic                      regWriteM,
    input  logic                      memWriteM,
    input  logic                      vecM,
    input  logic [DATA_W-1:0]         aluResM,
    input  logic [DATA_W-1:0]         PCPlus2M,
    input  logic [LANES*DATA_W-1:0]   writeDataM,
    input  logic [REG_W-1:0]          RdM,
    input  logic [1:0]                resultSrcM,
`ifdef VMEM_LANE_MASK_EN
    input  logic [LANES-1:0]          laneMaskM,
`endif
    output logic [DATA_W-1:0]         PCPlus2W,
    output logic [DATA_W-1:0]         aluResW,
    output logic [LANES*DATA_W-1:0]   readDataW,
    output logic [LANES*DATA_W-1:0]   writeDataW,
    output logic [REG_W-1:0]          RdW,
    output logic                      regWriteW,
    output logic [1:0]                resultSrcW,
    output logic                      stallM
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [VEC_W-1:0]  r_rdbuf;

    logic              w_idle;
    logic              w_scalar;
    logic              w_start_vec;
    logic              w_access;
    logic              w_last;
    logic              w_complete;
    logic              w_lane_en;
    logic              w_we;
    logic [IDX_W-1:0]  w_elem;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_rd;
    logic [DATA_W-1:0] w_wd;
    logic [VEC_W-1:0]  w_rd_vec;

    assign w_idle      = (r_state == S_IDLE);
    assign w_scalar    = w_idle & validM & ~vecM;
    assign w_start_vec = w_idle & validM & vecM;
    assign w_access    = (w_idle & validM) | ~w_idle;
    assign w_elem      = w_idle ? '0 : r_idx;
    assign w_last      = w_idle ? (w_start_vec & (LANES == 1)) : (r_idx == LAST_IDX);
    assign w_complete  = w_scalar | w_last;

    // Lane address wraps modulo DEPTH through the natural ADDR_W-bit add
    assign w_addr = aluResM[ADDR_W-1:0] + ADDR_W'(w_elem);
    assign w_rd   = r_mem[w_addr];
    assign w_wd   = writeDataM[int'(w_elem)*DATA_W +: DATA_W];

`ifdef VMEM_LANE_MASK_EN
    assign w_lane_en = ~vecM | laneMaskM[w_elem];
`else
    assign w_lane_en = 1'b1;
`endif

    assign w_we   = rst & w_access & memWriteM & w_lane_en;
    assign stallM = rst & (w_idle ? (w_start_vec & (LANES > 1)) : (r_idx != LAST_IDX));

    // Gather lanes; a new access in IDLE starts from an all-zero vector
    always_comb begin
        w_rd_vec = w_idle ? '0 : r_rdbuf;
        if (w_lane_en) begin
            w_rd_vec[int'(w_elem)*DATA_W +: DATA_W] = w_rd;
        end
    end

    // Array is never reset so contents survive an aborted vector
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_addr] <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_rdbuf    <= '0;
            PCPlus2W   <= '0;
            aluResW    <= '0;
            readDataW  <= '0;
            writeDataW <= '0;
            RdW        <= '0;
            regWriteW  <= 1'b0;
            resultSrcW <= 2'd0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_start_vec && (LANES > 1)) begin
                    r_state <= S_BUSY;
                    r_idx   <= IDX_W'(1);
                end
            end else begin
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            r_rdbuf <= w_rd_vec;

            // Completed op loads the W stage; anything else inserts a bubble
            if (w_complete) begin
                PCPlus2W   <= PCPlus2M;
                aluResW    <= aluResM;
                readDataW  <= w_rd_vec;
                writeDataW <= writeDataM;
                RdW        <= RdM;
                regWriteW  <= regWriteM;
                resultSrcW <= resultSrcM;
            end else begin
                regWriteW  <= 1'b0;
                resultSrcW <= 2'd0;
            end
        end
    end

    if (DATA_W > ADDR_W) begin : g_hi_addr
        logic w_unused_hi;
        assign w_unused_hi = ^aluResM[DATA_W-1:ADDR_W];
    end

endmodule

// File: tb/tb_vec_memory_stage.sv
// Directed table-driven bench for vec_memory_stage (LANES=4, DATA_W=16, ADDR_W=8).
module tb_vec_memory_stage;

    logic        clk;
    logic        rst;
    logic        validM, regWriteM, memWriteM, vecM;
    logic [15:0] aluResM, PCPlus2M;
    logic [63:0] writeDataM;
    logic [3:0]  RdM;
    logic [1:0]  resultSrcM;
`ifdef VMEM_LANE_MASK_EN
    logic [3:0]  lane_mask;
`endif
    logic [15:0] PCPlus2W, aluResW;
    logic [63:0] readDataW, writeDataW;
    logic [3:0]  RdW;
    logic        regWriteW;
    logic [1:0]  resultSrcW;
    logic        stallM;

    int n_checks = 0;
    int n_err    = 0;

    vec_memory_stage #(
        .DATA_W(16), .ADDR_W(8), .LANES(4), .REG_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .validM(validM), .regWriteM(regWriteM), .memWriteM(memWriteM), .vecM(vecM),
        .aluResM(aluResM), .PCPlus2M(PCPlus2M), .writeDataM(writeDataM),
        .RdM(RdM), .resultSrcM(resultSrcM),
`ifdef VMEM_LANE_MASK_EN
        .laneMaskM(lane_mask),
`endif
        .PCPlus2W(PCPlus2W), .aluResW(aluResW), .readDataW(readDataW),
        .writeDataW(writeDataW), .RdW(RdW), .regWriteW(regWriteW),
        .resultSrcW(resultSrcW), .stallM(stallM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rw;
        logic        mw;
        logic [7:0]  addr;
        logic [15:0] wd;
        logic [3:0]  rd;
        logic [1:0]  rs;
        logic        chk_rd;
        logic [15:0] exp_rd0;
        logic        exp_rw;
        logic [3:0]  exp_rdw;
        logic [1:0]  exp_rs;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        validM = 1'b0; vecM = 1'b0; memWriteM = 1'b0; regWriteM = 1'b0;
    endtask

    // Scalar load; W stage updates on the very next edge without stalling
    task automatic load(input logic [7:0] addr, input logic [15:0] exp, input string tag);
        validM = 1'b1; vecM = 1'b0; memWriteM = 1'b0; regWriteM = 1'b1;
        aluResM = {8'h00, addr}; RdM = 4'h9; resultSrcM = 2'd1;
        #1;
        chk({tag, " stall"}, 64'(stallM), 64'd0);
        @(posedge clk); #1;
        chk({tag, " data"}, readDataW, {48'h0, exp});
        chk({tag, " regWriteW"}, 64'(regWriteW), 64'd1);
        idle_inputs();
    endtask

    // Four-lane vector op: three stalled bubble edges, then the result edge
    task automatic vec_op(input logic [7:0] addr, input logic [63:0] wd, input logic mw,
                          input logic rw, input logic [3:0] rd, input logic chk_rd,
                          input logic [63:0] exp_rd, input string tag);
        validM = 1'b1; vecM = 1'b1; memWriteM = mw; regWriteM = rw;
        aluResM = {8'h00, addr}; PCPlus2M = 16'h0100 + 16'(addr);
        writeDataM = wd; RdM = rd; resultSrcM = 2'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk({tag, " stall"}, 64'(stallM), 64'd1);
            @(posedge clk); #1;
            chk({tag, " bubble regWriteW"}, 64'(regWriteW), 64'd0);
            chk({tag, " bubble resultSrcW"}, 64'(resultSrcW), 64'd0);
        end
        #1;
        chk({tag, " final stall"}, 64'(stallM), 64'd0);
        @(posedge clk); #1;
        chk({tag, " regWriteW"}, 64'(regWriteW), 64'(rw));
        chk({tag, " resultSrcW"}, 64'(resultSrcW), 64'd1);
        chk({tag, " RdW"}, 64'(RdW), 64'(rd));
        chk({tag, " aluResW"}, 64'(aluResW), {56'h0, addr});
        chk({tag, " PCPlus2W"}, 64'(PCPlus2W), 64'(16'h0100 + 16'(addr)));
        chk({tag, " writeDataW"}, writeDataW, wd);
        if (chk_rd) chk({tag, " readDataW"}, readDataW, exp_rd);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        aluResM = '0; PCPlus2M = '0; writeDataM = '0; RdM = '0; resultSrcM = '0;
`ifdef VMEM_LANE_MASK_EN
        lane_mask = 4'hF;
`endif

        // v, rw, mw, addr, wd, rd, rs, chk_rd, exp_rd0, exp_rw, exp_rdw, exp_rs
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'hAAAA, 4'd1, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd1, 2'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 16'h5678, 4'd2, 2'd0, 1'b1, 16'hAAAA, 1'b0, 4'd2, 2'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'd3, 2'd1, 1'b1, 16'h5678, 1'b1, 4'd3, 2'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 16'h1234, 4'd4, 2'd2, 1'b1, 16'h5678, 1'b0, 4'd3, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 16'h9999, 4'd6, 2'd3, 1'b1, 16'h5678, 1'b0, 4'd3, 2'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 4'd5, 2'd2, 1'b1, 16'h5678, 1'b1, 4'd5, 2'd2};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h22, 16'hC222, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h23, 16'hC223, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h30, 16'h0000, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h31, 16'h0000, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h32, 16'h0000, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h33, 16'h0000, 4'd0, 2'd0, 1'b0, 16'h0000, 1'b0, 4'd0, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset regWriteW", 64'(regWriteW), 64'd0);
        chk("reset readDataW", readDataW, 64'd0);
        chk("reset RdW", 64'(RdW), 64'd0);
        chk("reset stallM", 64'(stallM), 64'd0);
        rst = 1'b1;

        // Scalar stores/loads and validM=0 bubbles
        for (int i = 0; i < 12; i++) begin
            validM = tbl[i].v; vecM = 1'b0; regWriteM = tbl[i].rw; memWriteM = tbl[i].mw;
            aluResM = {8'h00, tbl[i].addr}; writeDataM = {48'h0, tbl[i].wd};
            RdM = tbl[i].rd; resultSrcM = tbl[i].rs;
            #1;
            chk($sformatf("tbl%0d stall", i), 64'(stallM), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d regWriteW", i), 64'(regWriteW), 64'(tbl[i].exp_rw));
            chk($sformatf("tbl%0d RdW", i), 64'(RdW), 64'(tbl[i].exp_rdw));
            chk($sformatf("tbl%0d resultSrcW", i), 64'(resultSrcW), 64'(tbl[i].exp_rs));
            if (tbl[i].chk_rd)
                chk($sformatf("tbl%0d readDataW", i), readDataW, {48'h0, tbl[i].exp_rd0});
        end
        idle_inputs();

        // Vector store then load at 0x10
        vec_op(8'h10, 64'h4444_3333_2222_1111, 1'b1, 1'b0, 4'd2, 1'b0, 64'h0, "vst10");
        vec_op(8'h10, 64'h0, 1'b0, 1'b1, 4'd7, 1'b1, 64'h4444_3333_2222_1111, "vld10");

        // Wrap from 0xFF to 0x00
        vec_op(8'hFE, 64'hD004_D003_D002_D001, 1'b1, 1'b0, 4'd1, 1'b0, 64'h0, "vstFE");
        load(8'hFE, 16'hD001, "ldFE");
        load(8'hFF, 16'hD002, "ldFF");
        load(8'h00, 16'hD003, "ld00");
        load(8'h01, 16'hD004, "ld01");
        vec_op(8'hFE, 64'h0, 1'b0, 1'b1, 4'd3, 1'b1, 64'hD004_D003_D002_D001, "vldFE");
        load(8'h01, 16'hD004, "ld01b");

        // Reset while the vector store at 0x20 is on lane 2
        validM = 1'b1; vecM = 1'b1; memWriteM = 1'b1; regWriteM = 1'b0;
        aluResM = 16'h0020; writeDataM = 64'hE004_E003_E002_E001; RdM = 4'd7; resultSrcM = 2'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst pre stall", 64'(stallM), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst readDataW", readDataW, 64'd0);
        chk("rst aluResW", 64'(aluResW), 64'd0);
        chk("rst RdW", 64'(RdW), 64'd0);
        chk("rst PCPlus2W", 64'(PCPlus2W), 64'd0);
        chk("rst writeDataW", writeDataW, 64'd0);
        chk("rst stallM", 64'(stallM), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        #1 rst = 1'b1;
        load(8'h20, 16'hE001, "ld20");
        load(8'h21, 16'hE002, "ld21");
        load(8'h22, 16'hC222, "ld22");
        load(8'h23, 16'hC223, "ld23");

`ifdef VMEM_LANE_MASK_EN
        lane_mask = 4'b0101;
        vec_op(8'h30, 64'hF004_F003_F002_F001, 1'b1, 1'b0, 4'd1, 1'b1, 64'h0, "mst30");
        lane_mask = 4'hF;
        vec_op(8'h30, 64'h0, 1'b0, 1'b1, 4'd2, 1'b1, 64'h0000_F003_0000_F001, "mld30");
`else
        vec_op(8'h30, 64'h0, 1'b0, 1'b1, 4'd2, 1'b1, 64'h0, "vld30");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
